// File: rtl/addb_pkg.sv
// Shared types and arithmetic helpers for the multi-channel reconstruction adder.
// Helpers work at MAXW+1 bits; callers keep only the low W bits they need.
package addb_pkg;

  localparam int DEF_W    = 16;
  localparam int DEF_NCH  = 4;
  localparam int MAXW     = 32;
  localparam int MAX_CH_W = 8;

  typedef struct packed {
    logic [MAXW:0]       dqi;
    logic [MAXW:0]       sei;
    logic [MAX_CH_W-1:0] ch;
  } s1_t;

  typedef struct packed {
    logic          ovf;
    logic [MAXW:0] val;
  } sat_t;

  // Negative zero (sign set, magnitude 0) naturally maps to 0.
  function automatic logic [MAXW:0] sm2tc(input logic sign, input logic [MAXW-1:0] mag);
    logic [MAXW:0] m;
    m = {1'b0, mag};
    return sign ? (~m + 1'b1) : m;
  endfunction

  function automatic sat_t sat_w(input logic [MAXW:0] s, input int unsigned w,
                                 input logic clamp);
    logic signed [MAXW:0] ss;
    logic signed [MAXW:0] hi;
    logic signed [MAXW:0] lo;
    sat_t r;
    ss = $signed(s);
    hi = $signed(({{MAXW{1'b0}}, 1'b1} << (w - 1)) - 1'b1);
    lo = ~hi;
    r.ovf = (ss > hi) || (ss < lo);
    r.val = s;
    if (clamp && (ss > hi)) begin
      r.val = hi;
    end else if (clamp && (ss < lo)) begin
      r.val = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/addb_hist.sv
// Per-channel two-deep history of reconstructed samples: shift on write,
// clear wins over a same-cycle write, combinational read (0 for unknown channel).
module addb_hist #(
  parameter  int W    = 16,
  parameter  int NCH  = 4,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en_i,
  input  logic [CH_W-1:0] wr_ch_i,
  input  logic [W-1:0]    wr_data_i,
  input  logic            clr_i,
  input  logic [CH_W-1:0] clr_ch_i,
  input  logic [CH_W-1:0] rd_ch_i,
  output logic [W-1:0]    rd_sr1_o,
  output logic [W-1:0]    rd_sr2_o
);

  logic [W-1:0] sr1_q [NCH];
  logic [W-1:0] sr2_q [NCH];
  logic [W-1:0] sr1_d [NCH];
  logic [W-1:0] sr2_d [NCH];

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      sr1_d[i] = sr1_q[i];
      sr2_d[i] = sr2_q[i];
      if (clr_i && (clr_ch_i == CH_W'(i))) begin
        sr1_d[i] = '0;
        sr2_d[i] = '0;
      end else if (wr_en_i && (wr_ch_i == CH_W'(i))) begin
        sr1_d[i] = wr_data_i;
        sr2_d[i] = sr1_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        sr1_q[i] <= '0;
        sr2_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        sr1_q[i] <= sr1_d[i];
        sr2_q[i] <= sr2_d[i];
      end
    end
  end

  // Channel codes with no matching entry fall through to 0.
  always_comb begin
    rd_sr1_o = '0;
    rd_sr2_o = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_ch_i == CH_W'(i)) begin
        rd_sr1_o = sr1_q[i];
        rd_sr2_o = sr2_q[i];
      end
    end
  end

endmodule

// File: rtl/addb_mc.sv
// Two-stage multi-channel reconstruction adder SR = DQ (sign-magnitude) + SE,
// with valid/ready flow control, optional saturation and per-channel history.
module addb_mc
  import addb_pkg::*;
#(
  parameter  int W    = DEF_W,
  parameter  int NCH  = DEF_NCH,
  parameter  int SAT  = 1,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            scan_in0,
  input  logic            scan_in1,
  input  logic            scan_in2,
  input  logic            scan_in3,
  input  logic            scan_in4,
  input  logic            scan_enable,
  input  logic            test_mode,
  output logic            scan_out0,
  output logic            scan_out1,
  output logic            scan_out2,
  output logic            scan_out3,
  output logic            scan_out4,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH_W-1:0] in_ch,
  input  logic [W-1:0]    DQ,
  input  logic [W-2:0]    SE,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH_W-1:0] out_ch,
  output logic [W-1:0]    SR,
  output logic            ovf,
  input  logic [CH_W-1:0] rd_ch,
  output logic [W-1:0]    rd_sr1,
  output logic [W-1:0]    rd_sr2,
  input  logic            clr,
  input  logic [CH_W-1:0] clr_ch
);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and a stalled result holds its payload.

  // Scan chain is stitched at synthesis; these are placeholders.
  assign scan_out0 = scan_in0;
  assign scan_out1 = scan_in1;
  assign scan_out2 = scan_in2;
  assign scan_out3 = scan_in3;
  assign scan_out4 = scan_in4;

  s1_t             s1_q, s1_d, in_pl;
  logic            s1_valid_q, s1_valid_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    sr_q, sr_d;
  logic            ovf_q, ovf_d;
  logic [CH_W-1:0] out_ch_q, out_ch_d;
  logic [MAXW:0]   sum;
  sat_t            res;
  logic            out_fire, s2_free, s1_move, accept;

  assign out_fire = out_valid_q && out_ready;
  assign s2_free  = !out_valid_q || out_ready;
  assign s1_move  = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s1_move;
  assign accept   = in_valid && in_ready;

  always_comb begin
    in_pl.dqi = sm2tc(DQ[W-1], MAXW'(DQ[W-2:0]));
    in_pl.sei = {{(MAXW + 2 - W){SE[W-2]}}, SE};
    in_pl.ch  = MAX_CH_W'(in_ch);
  end

  assign sum = s1_q.dqi + s1_q.sei;
  assign res = sat_w(sum, W, SAT != 0);

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    sr_d        = sr_q;
    ovf_d       = ovf_q;
    out_ch_d    = out_ch_q;
    if (accept) begin
      s1_valid_d = 1'b1;
      s1_d       = in_pl;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end
    if (s1_move) begin
      out_valid_d = 1'b1;
      sr_d        = res.val[W-1:0];
      ovf_d       = res.ovf;
      out_ch_d    = s1_q.ch[CH_W-1:0];
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      sr_q        <= '0;
      ovf_q       <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      sr_q        <= sr_d;
      ovf_q       <= ovf_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign SR        = sr_q;
  assign ovf       = ovf_q;
  assign out_ch    = out_ch_q;

  addb_hist #(
    .W  (W),
    .NCH(NCH)
  ) u_hist (
    .clk      (clk),
    .rst_n    (reset),
    .wr_en_i  (out_fire),
    .wr_ch_i  (out_ch_q),
    .wr_data_i(sr_q),
    .clr_i    (clr),
    .clr_ch_i (clr_ch),
    .rd_ch_i  (rd_ch),
    .rd_sr1_o (rd_sr1),
    .rd_sr2_o (rd_sr2)
  );

endmodule

// File: tb/tb_addb_mc.sv
// Bench for addb_mc: a saturating and a wrapping instance share stimulus and
// are checked against an arithmetic reference model with an expected queue.
module tb_addb_mc;

  localparam int W    = 16;
  localparam int NCH  = 4;
  localparam int CH_W = 2;
  localparam int EW   = CH_W + 1 + 2 * W;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic [CH_W-1:0] in_ch = '0;
  logic [W-1:0]    DQ = '0;
  logic [W-2:0]    SE = '0;
  logic            out_ready = 1'b1;
  logic [CH_W-1:0] rd_ch = '0;
  logic            clr = 1'b0;
  logic [CH_W-1:0] clr_ch = '0;

  logic            in_ready, out_valid, ovf;
  logic [CH_W-1:0] out_ch;
  logic [W-1:0]    SR, rd_sr1, rd_sr2;
  logic            in_ready_w, out_valid_w, ovf_w;
  logic [CH_W-1:0] out_ch_w;
  logic [W-1:0]    SR_w, rd_sr1_w, rd_sr2_w;
  logic [4:0]      so_s, so_w;

  int checks = 0;
  int failures = 0;
  int n_out = 0;

  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  m_sr1[NCH];
  logic [W-1:0]  m_sr2[NCH];
  logic          stall_prev = 1'b0;
  logic [W-1:0]  held_sr;
  logic [CH_W-1:0] held_ch;
  logic          held_ovf;
  logic [EW-1:0] sb_e, sb_act;
  logic [W-1:0]  sb_e1, sb_e2;

  always #5 clk = ~clk;

  addb_mc #(.W(W), .NCH(NCH), .SAT(1)) u_sat (
    .clk(clk), .reset(reset),
    .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0), .scan_in4(1'b0),
    .scan_enable(1'b0), .test_mode(1'b0),
    .scan_out0(so_s[0]), .scan_out1(so_s[1]), .scan_out2(so_s[2]), .scan_out3(so_s[3]),
    .scan_out4(so_s[4]),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .DQ(DQ), .SE(SE),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .SR(SR), .ovf(ovf),
    .rd_ch(rd_ch), .rd_sr1(rd_sr1), .rd_sr2(rd_sr2), .clr(clr), .clr_ch(clr_ch)
  );

  addb_mc #(.W(W), .NCH(NCH), .SAT(0)) u_wrap (
    .clk(clk), .reset(reset),
    .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0), .scan_in4(1'b0),
    .scan_enable(1'b0), .test_mode(1'b0),
    .scan_out0(so_w[0]), .scan_out1(so_w[1]), .scan_out2(so_w[2]), .scan_out3(so_w[3]),
    .scan_out4(so_w[4]),
    .in_valid(in_valid), .in_ready(in_ready_w), .in_ch(in_ch), .DQ(DQ), .SE(SE),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_ch(out_ch_w), .SR(SR_w), .ovf(ovf_w),
    .rd_ch(rd_ch), .rd_sr1(rd_sr1_w), .rd_sr2(rd_sr2_w), .clr(clr), .clr_ch(clr_ch)
  );

  // Reference: plain integer arithmetic on the decoded operands.
  // Packed as {ch, ovf, saturated SR, wrapped SR}.
  function automatic logic [EW-1:0] model(input logic [W-1:0] dq, input logic [W-2:0] se,
                                          input logic [CH_W-1:0] ch);
    int dqi, sei, s, sat_v;
    logic o;
    logic [31:0] su;
    dqi   = dq[W-1] ? -int'(dq[W-2:0]) : int'(dq[W-2:0]);
    sei   = int'($signed(se));
    s     = dqi + sei;
    o     = (s > 32767) || (s < -32768);
    sat_v = (s > 32767) ? 32767 : ((s < -32768) ? -32768 : s);
    su    = s;
    return {ch, o, 16'(sat_v), su[15:0]};
  endfunction

  // Scoreboard, read-port model and stall-stability monitor.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      for (int i = 0; i < NCH; i++) begin
        m_sr1[i] = '0;
        m_sr2[i] = '0;
      end
      stall_prev = 1'b0;
    end else begin
      sb_e1 = m_sr1[rd_ch];
      sb_e2 = m_sr2[rd_ch];
      checks++;
      if (rd_sr1 !== sb_e1 || rd_sr2 !== sb_e2) begin
        failures++;
        $display("FAIL read_port ch=%0d: got sr1=%h sr2=%h expected sr1=%h sr2=%h",
                 rd_ch, rd_sr1, rd_sr2, sb_e1, sb_e2);
      end
      checks++;
      if (out_valid_w !== out_valid) begin
        failures++;
        $display("FAIL wrap_valid: got %b expected %b", out_valid_w, out_valid);
      end
      if (stall_prev && out_valid) begin
        checks++;
        if (SR !== held_sr || out_ch !== held_ch || ovf !== held_ovf) begin
          failures++;
          $display("FAIL stall_stable: got sr=%h ch=%0d ovf=%b expected sr=%h ch=%0d ovf=%b",
                   SR, out_ch, ovf, held_sr, held_ch, held_ovf);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output: got sr=%h ch=%0d expected no output", SR, out_ch);
        end else begin
          sb_e   = exp_q.pop_front();
          sb_act = {out_ch, ovf, SR, SR_w};
          n_out++;
          if (sb_act !== sb_e || ovf_w !== sb_e[2*W]) begin
            failures++;
            $display("FAIL output: got ch=%0d ovf=%b/%b sr=%h wrap=%h expected ch=%0d ovf=%b sr=%h wrap=%h",
                     out_ch, ovf, ovf_w, SR, SR_w, sb_e[EW-1 -: CH_W], sb_e[2*W],
                     sb_e[2*W-1:W], sb_e[W-1:0]);
          end
          m_sr2[sb_e[EW-1 -: CH_W]] = m_sr1[sb_e[EW-1 -: CH_W]];
          m_sr1[sb_e[EW-1 -: CH_W]] = sb_e[2*W-1:W];
        end
      end
      if (clr) begin
        m_sr1[clr_ch] = '0;
        m_sr2[clr_ch] = '0;
      end
      if (in_valid && in_ready) exp_q.push_back(model(DQ, SE, in_ch));
      stall_prev = out_valid && !out_ready;
      held_sr    = SR;
      held_ch    = out_ch;
      held_ovf   = ovf;
    end
  end

  function automatic logic [W-1:0] rand_dq();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'hFFFF;
      2: return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Sends one sample; lat = edges from the accepting edge until out_valid.
  task automatic send_one(input logic [W-1:0] dq, input logic [W-2:0] se,
                          input logic [CH_W-1:0] ch, output int lat);
    int n;
    in_valid = 1'b1;
    DQ = dq;
    SE = se;
    in_ch = ch;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    lat = n;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || SR !== '0 || ovf !== 1'b0 || out_ch !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b sr=%h ovf=%b ch=%0d expected 0 0 0 0",
               out_valid, SR, ovf, out_ch);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] v_dq[5], v_sat[5], v_wrap[5];
    logic [W-2:0] v_se[5];
    logic         v_ovf[5];
    int lat;
    v_dq   = '{16'h0005, 16'h8005, 16'h8000, 16'h7FFF, 16'hFFFF};
    v_se   = '{15'h0003, 15'h7FFD, 15'h0000, 15'h3FFF, 15'h4000};
    v_sat  = '{16'h0008, 16'hFFF8, 16'h0000, 16'h7FFF, 16'h8000};
    v_wrap = '{16'h0008, 16'hFFF8, 16'h0000, 16'hBFFE, 16'h4001};
    v_ovf  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_one(v_dq[i], v_se[i], CH_W'(i % 2), lat);
      // Accept in cycle c, out_valid in cycle c+2: one more edge after the accepting one.
      checks++;
      if (lat != 1) begin
        failures++;
        $display("FAIL latency_%0d: got %0d extra edges expected 1", i, lat);
      end
      checks++;
      if (SR !== v_sat[i] || SR_w !== v_wrap[i] || ovf !== v_ovf[i] || ovf_w !== v_ovf[i]) begin
        failures++;
        $display("FAIL vector_%0d: got sat=%h wrap=%h ovf=%b/%b expected sat=%h wrap=%h ovf=%b",
                 i, SR, SR_w, ovf, ovf_w, v_sat[i], v_wrap[i], v_ovf[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_history();
    int lat;
    out_ready = 1'b1;
    send_one(16'h0010, 15'h0000, 2'd2, lat);
    send_one(16'h0020, 15'h0000, 2'd2, lat);
    @(posedge clk); #1;
    rd_ch = 2'd2;
    #1;
    checks++;
    if (rd_sr1 !== 16'h0020 || rd_sr2 !== 16'h0010) begin
      failures++;
      $display("FAIL history_ch2: got sr1=%h sr2=%h expected sr1=0020 sr2=0010", rd_sr1, rd_sr2);
    end
    out_ready = 1'b0;
    send_one(16'h0030, 15'h0000, 2'd2, lat);
    clr = 1'b1;
    clr_ch = 2'd2;
    out_ready = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || rd_sr1 !== '0 || rd_sr2 !== '0) begin
      failures++;
      $display("FAIL clear_wins: got v=%b sr1=%h sr2=%h expected v=0 sr1=0000 sr2=0000",
               out_valid, rd_sr1, rd_sr2);
    end
  endtask

  task automatic test_back_to_back();
    int base, not_ready;
    base = n_out;
    not_ready = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      DQ = rand_dq();
      SE = 15'($urandom);
      in_ch = CH_W'($urandom_range(0, 3));
      #1;
      if (!in_ready) not_ready++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (not_ready != 0 || n_out - base != 16) begin
      failures++;
      $display("FAIL back_to_back: got stalls=%0d outputs=%0d expected stalls=0 outputs=16",
               not_ready, n_out - base);
    end
  endtask

  task automatic test_backpressure();
    int sent, n, base;
    logic acc;
    sent = 0;
    n = 0;
    base = n_out;
    in_valid = 1'b0;
    while (sent < 40 && n < 2000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        DQ = rand_dq();
        SE = 15'($urandom);
        in_ch = CH_W'($urandom_range(0, 3));
      end
      out_ready = 1'($urandom_range(0, 1));
      rd_ch = CH_W'($urandom_range(0, 3));
      clr = ($urandom_range(0, 15) == 0);
      clr_ch = CH_W'($urandom_range(0, 3));
      #1;
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      n++;
      if (acc) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    clr = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sent != 40 || n_out - base != 40 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL backpressure_count: got sent=%0d out=%0d pending=%0d expected 40 40 0",
               sent, n_out - base, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    out_ready = 1'b0;
    in_valid = 1'b1;
    DQ = 16'h0123;
    SE = 15'h0001;
    in_ch = 2'd3;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL pipe_full: got in_ready=%b out_valid=%b expected 0 1", in_ready, out_valid);
    end
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || SR !== '0 || ovf !== 1'b0 || out_ch !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got v=%b sr=%h ovf=%b ch=%0d expected 0 0 0 0",
               out_valid, SR, ovf, out_ch);
    end
    for (int c = 0; c < NCH; c++) begin
      rd_ch = CH_W'(c);
      #1;
      checks++;
      if (rd_sr1 !== '0 || rd_sr2 !== '0) begin
        failures++;
        $display("FAIL midreset_hist_%0d: got sr1=%h sr2=%h expected 0000 0000", c, rd_sr1, rd_sr2);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
    end
    send_one(16'h0005, 15'h0003, 2'd1, lat);
    checks++;
    if (lat != 1 || SR !== 16'h0008) begin
      failures++;
      $display("FAIL post_reset_first: got lat=%0d sr=%h expected lat=1 sr=0008", lat, SR);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_history();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got no completion expected finish before 500000 time units");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/addb_mc.md
# addb_mc

Multi-channel, pipelined successor to the ADPCM reconstruction adder. It computes SR = DQ + SE for up to NCH time-multiplexed channels. DQ is sign-magnitude and SE is two's complement. Over a single-resource datapath it adds:
- a valid/ready handshake,
- optional saturation with an overflow flag,
- a per-channel two-deep history of reconstructed samples, SR(k-1) and SR(k-2), for the predictor and tone-detection blocks downstream.

## Interface
Parameters:
- W, 16, DQ and SR width. SE width is W-1.
- NCH, 4, number of channels (≥1). CH_W = max(1, $clog2(NCH)).
- SAT, 1. 1 = clamp to the signed W-bit range; 0 = wrap modulo 2^W, bit-identical to the legacy adder.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- scan_in0..scan_in4, scan_enable, test_mode  in  1  test scan inputs.
- scan_out0..scan_out4  out  1  test scan outputs.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_ch  in  CH_W  channel tag of the input sample.
- DQ  in  W  quantized difference, sign-magnitude (MSB = sign).
- SE  in  W-1  signal estimate, two's complement.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_ch  out  CH_W  channel tag of the result.
- SR  out  W  reconstructed signal, two's complement.
- ovf  out  1  saturation or wrap occurred for this result.
- rd_ch  in  CH_W  history read select.
- rd_sr1, rd_sr2  out  W  SR(k-1) and SR(k-2) of channel rd_ch.
- clr  in  1  synchronous clear of the history selected by clr_ch.
- clr_ch  in  CH_W  channel to clear.

## Operation
- Stage 1 (convert), on input accept (in_valid && in_ready):
  - DQI = DQ[W-1] ? -DQ[W-2:0] : DQ[W-2:0], at W+1 bits.
  - SEI = SE sign-extended to W+1 bits.
  - DQ = 1000…0 (negative zero) converts to 0.
  - Channel tag is registered alongside.
- Stage 2 (add):
  - S = DQI + SEI at W+1 bits.
  - ovf = S outside [-2^(W-1), 2^(W-1)-1].
  - SAT=1: SR = clamp(S). SAT=0: SR = S[W-1:0].
  - ovf is reported in both modes.
- Pipeline control:
  - s2 holds while out_valid && !out_ready.
  - s1 moves to s2 when s2 is empty or s2 is draining.
  - in_ready = !s1_valid || s1 moves. in_ready depends combinationally on out_ready.
  - No bubbles are inserted; no sample is dropped or duplicated.
- History update:
  - On output handshake (out_valid && out_ready), channel out_ch shifts: sr2 ← sr1, sr1 ← SR.
  - Other channels are untouched.
- Clear: clr clears sr1 and sr2 of clr_ch to 0. If it coincides with an update of the same channel, the clear wins.
- Read port: rd_sr1/rd_sr2 are combinational from the registers and return pre-update values in the cycle an update occurs.
- in_ch/clr_ch/rd_ch ≥ NCH: the sample still flows through; history update, clear and read are suppressed; reads return 0.

## Timing
- Latency: 2 cycles from input accept to out_valid, with out_ready held high.
- Throughput: 1 sample/cycle.
- Stall: SR, out_ch and ovf are held stable while out_valid && !out_ready.
- Reset (asserted low, any time, including mid-transfer):
  - s1_valid, out_valid → 0.
  - SR, out_ch, ovf → 0.
  - All history → 0.
  - in_ready → 1 the cycle after deassertion.
  - In-flight samples are discarded.
- Reset deassertion is synchronised by the existing reset synchroniser upstream; the block itself needs no synchronisation.

## Structure
- Shared package addb_pkg:
  - defaults W=16, NCH=4.
  - function sm2tc (sign-magnitude to two's complement).
  - function sat_w (clamp with overflow flag).
  - typedef for the stage-1 payload (dqi, sei, ch).
- Sub-module addb_hist: NCH×2 register bank with shift-on-write, clear and combinational read; parameterised by W, NCH.
- Scan ports are pass-through stubs, inserted at synthesis.

## Test plan
- Basic, W=16: DQ=0x0005, SE=0x0003 → SR=0x0008, ovf=0, two cycles after accept. DQ=0x8005, SE=0x7FFD → SR=0xFFF8.
- Negative zero: DQ=0x8000, SE=0x0000 → SR=0x0000, ovf=0.
- Overflow, positive: DQ=0x7FFF, SE=0x3FFF → SAT=1: SR=0x7FFF, ovf=1. SAT=0: SR=0xBFFE, ovf=1.
- Overflow, negative: DQ=0xFFFF, SE=0x4000 → SAT=1: SR=0x8000, ovf=1. SAT=0: SR=0x4001, ovf=1.
- Backpressure: stream 8 samples on channels 0-3 with out_ready toggling pseudo-randomly → output order and values match a reference model; no loss or duplication; SR stable during stalls.
- History, reset, clear:
  - Channel 2 receives SR=0x0010 then 0x0020 → rd_sr1=0x0020, rd_sr2=0x0010.
  - clr on channel 2 in the same cycle as an update → both 0.
  - Reset asserted with both stages full → all outputs and history 0; the first post-reset sample has 2-cycle latency.
